s_axi_intr_ctrl: RTL and testbench

S_AXI_INTR_CTRL -- requirements
Module: s_axi_intr_ctrl

---
 rtl/s_axi_intr_ctrl.sv | 175 +++++++++++++++++
 tb/tb_s_axi_intr_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_axi_intr_ctrl.sv
// rtl/s_axi_intr_ctrl.sv - AXI4-Lite interrupt controller with level/edge sources and a registered irq
module s_axi_intr_ctrl #(
    parameter int C_NUM_OF_INTR = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_IRQ_ACTIVE_STATE = 1,
    parameter logic [C_NUM_OF_INTR-1:0] C_MODE_RESET = '0
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_areset,
    input  logic [C_NUM_OF_INTR-1:0]        intr_in,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            irq
);

    localparam int N  = C_NUM_OF_INTR;
    localparam int W  = C_S_AXI_DATA_WIDTH;
    localparam int OW = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [OW-1:0] OffGie  = OW'(0);
    localparam logic [OW-1:0] OffIer  = OW'(1);
    localparam logic [OW-1:0] OffIsr  = OW'(2);
    localparam logic [OW-1:0] OffIar  = OW'(3);
    localparam logic [OW-1:0] OffIpr  = OW'(4);
    localparam logic [OW-1:0] OffMode = OW'(5);
    localparam logic [OW-1:0] OffIswr = OW'(6);

    localparam logic IrqOn = (C_IRQ_ACTIVE_STATE != 0);

    logic           gie;
    logic [N-1:0]   ier;
    logic [N-1:0]   mode;
    logic [N-1:0]   ipr;
    logic [N-1:0]   intrPrev;
    logic           irqReg;
    logic           bValid;
    logic           rValid;
    logic [W-1:0]   rData;

    logic           wrAccept;
    logic           rdAccept;
    logic [OW-1:0]  wrOff;
    logic [OW-1:0]  rdOff;
    logic [W-1:0]   wMask;
    logic [W-1:0]   wStrobed;
    logic [N-1:0]   wMaskN;
    logic [N-1:0]   wStrobedN;
    logic [N-1:0]   iarClr;
    logic [N-1:0]   iswrSet;
    logic [N-1:0]   evt;
    logic [N-1:0]   iprNext;
    logic [W-1:0]   rdMux;
    logic           unusedBits;

    // Ready is combinational on valid so address+data are taken in one cycle;
    // an outstanding response blocks the next acceptance.
    assign wrAccept = s_axi_awvalid & s_axi_wvalid & ~bValid & ~s_axi_areset;
    assign rdAccept = s_axi_arvalid & ~rValid & ~s_axi_areset;

    assign s_axi_awready = wrAccept;
    assign s_axi_wready  = wrAccept;
    assign s_axi_arready = rdAccept;
    assign s_axi_bvalid  = bValid;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rvalid  = rValid;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rdata   = rData;
    assign irq           = irqReg;

    assign wrOff = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rdOff = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    always_comb begin
        wMask = '0;
        for (int b = 0; b < W / 8; b++) begin
            wMask[8*b +: 8] = {8{s_axi_wstrb[b]}};
        end
    end

    assign wStrobed  = s_axi_wdata & wMask;
    assign wStrobedN = wStrobed[N-1:0];
    assign wMaskN    = wMask[N-1:0];

    assign iarClr  = (wrAccept && wrOff == OffIar)  ? wStrobedN : '0;
    assign iswrSet = (wrAccept && wrOff == OffIswr) ? wStrobedN : '0;

    // Sets dominate a same-cycle acknowledge so no event is ever lost.
    assign evt     = (mode & intr_in & ~intrPrev) | (~mode & intr_in);
    assign iprNext = (ipr & ~iarClr) | (evt & ier) | iswrSet;

    assign unusedBits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                          s_axi_araddr[1:0], wStrobed, wMask};

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            gie  <= 1'b0;
            ier  <= '0;
            mode <= C_MODE_RESET;
        end else if (wrAccept) begin
            case (wrOff)
                OffGie:  if (s_axi_wstrb[0]) gie <= s_axi_wdata[0];
                OffIer:  ier  <= (ier & ~wMaskN) | wStrobedN;
                OffMode: mode <= (mode & ~wMaskN) | wStrobedN;
                default: ;
            endcase
        end
    end

    // intrPrev follows intr_in every cycle, so a MODE change always starts
    // edge detection from the current input level.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            ipr      <= '0;
            intrPrev <= '0;
            irqReg   <= ~IrqOn;
        end else begin
            ipr      <= iprNext;
            intrPrev <= intr_in;
            irqReg   <= (gie && |ipr) ? IrqOn : ~IrqOn;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            bValid <= 1'b0;
        end else if (wrAccept) begin
            bValid <= 1'b1;
        end else if (s_axi_bready) begin
            bValid <= 1'b0;
        end
    end

    always_comb begin
        rdMux = '0;
        case (rdOff)
            OffGie:  rdMux[0]     = gie;
            OffIer:  rdMux[N-1:0] = ier;
            OffIsr:  rdMux[N-1:0] = intr_in;
            OffIpr:  rdMux[N-1:0] = ipr;
            OffMode: rdMux[N-1:0] = mode;
            default: ;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            rValid <= 1'b0;
            rData  <= '0;
        end else if (rdAccept) begin
            rValid <= 1'b1;
            rData  <= rdMux;
        end else if (s_axi_rready) begin
            rValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_s_axi_intr_ctrl.sv
// tb/tb_s_axi_intr_ctrl.sv - directed self-checking bench for s_axi_intr_ctrl (4 sources)
module tb_s_axi_intr_ctrl;

    logic        tb_ACLK = 1'b0;
    logic        areset;
    logic [3:0]  intrIn;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        irq;

    int checkCount = 0;
    int errorCount = 0;
    logic [31:0] rd;

    always #5 tb_ACLK = ~tb_ACLK;

    s_axi_intr_ctrl #(
        .C_NUM_OF_INTR(4),
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .C_IRQ_ACTIVE_STATE(1),
        .C_MODE_RESET(4'b0000)
    ) dut (
        .s_axi_aclk(tb_ACLK),
        .s_axi_areset(areset),
        .intr_in(intrIn),
        .s_axi_awaddr(awaddr),
        .s_axi_awprot(awprot),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bresp(bresp),
        .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_araddr(araddr),
        .s_axi_arprot(arprot),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata(rdata),
        .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid),
        .s_axi_rready(rready),
        .irq(irq)
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [3:0] pulse, input bit waitResp);
        int n;
        @(posedge tb_ACLK); #1;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        intrIn = intrIn | pulse;
        n = 0;
        do begin
            @(negedge tb_ACLK);
            n++;
        end while (!(awready && wready) && n < 50);
        checkValue("wrAccept", {31'b0, awready && wready}, 32'h1);
        @(posedge tb_ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        intrIn = intrIn & ~pulse;
        if (waitResp) begin
            n = 0;
            while (!bvalid && n < 50) begin
                @(negedge tb_ACLK);
                n++;
            end
            checkValue("bvalid", {31'b0, bvalid}, 32'h1);
            checkValue("bresp", {30'b0, bresp}, 32'h0);
            @(posedge tb_ACLK); #1;
        end
    endtask

    task automatic axiRead(input logic [4:0] addr, output logic [31:0] data);
        int n;
        @(posedge tb_ACLK); #1;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        do begin
            @(negedge tb_ACLK);
            n++;
        end while (!arready && n < 50);
        checkValue("arready", {31'b0, arready}, 32'h1);
        @(posedge tb_ACLK); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin
            @(negedge tb_ACLK);
            n++;
        end
        checkValue("rvalid", {31'b0, rvalid}, 32'h1);
        checkValue("rresp", {30'b0, rresp}, 32'h0);
        data = rdata;
        @(posedge tb_ACLK); #1;
    endtask

    task automatic readCheck(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        axiRead(addr, v);
        checkValue(tag, v, exp);
    endtask

    initial begin
        areset = 1'b1; intrIn = 4'h0;
        awaddr = '0; awprot = 3'b000; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b1;
        repeat (3) @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        checkValue("rstIrq", {31'b0, irq}, 32'h0);
        checkValue("rstBvalid", {31'b0, bvalid}, 32'h0);
        checkValue("rstRvalid", {31'b0, rvalid}, 32'h0);
        checkValue("rstRdata", rdata, 32'h0);
        @(posedge tb_ACLK); #1;
        areset = 1'b0;

        readCheck("rstGie", 5'h00, 32'h0);
        readCheck("rstIer", 5'h04, 32'h0);
        readCheck("rstIpr", 5'h10, 32'h0);
        readCheck("rstMode", 5'h14, 32'h0);

        // Full-word writes; only implemented bits read back.
        axiWrite(5'h00, 32'h0101FFFF, 4'hF, 4'h0, 1'b1);
        axiWrite(5'h04, 32'h0101FFFF, 4'hF, 4'h0, 1'b1);
        axiWrite(5'h14, 32'h0101FFFF, 4'hF, 4'h0, 1'b1);
        readCheck("gieRb", 5'h00, 32'h1);
        readCheck("ierRb", 5'h04, 32'hF);
        readCheck("modeRb", 5'h14, 32'hF);
        axiWrite(5'h04, 32'h0, 4'hE, 4'h0, 1'b1);
        readCheck("ierStrb", 5'h04, 32'hF);
        axiWrite(5'h00, 32'h0, 4'h0, 4'h0, 1'b1);
        readCheck("gieStrb", 5'h00, 32'h1);
        axiWrite(5'h14, 32'h0, 4'hF, 4'h0, 1'b1);
        axiWrite(5'h04, 32'h1, 4'hF, 4'h0, 1'b1);
        readCheck("ierSet", 5'h04, 32'h1);

        // Level pulse on source 0: irq follows two edges later.
        @(posedge tb_ACLK); #1;
        intrIn = 4'h1;
        @(negedge tb_ACLK);
        checkValue("irqPre0", {31'b0, irq}, 32'h0);
        @(posedge tb_ACLK); #1;
        intrIn = 4'h0;
        checkValue("irqPre1", {31'b0, irq}, 32'h0);
        @(posedge tb_ACLK); #1;
        checkValue("irqLat2", {31'b0, irq}, 32'h1);
        readCheck("iprPulse", 5'h10, 32'h1);
        intrIn = 4'h5;
        readCheck("isrRaw", 5'h08, 32'h5);
        intrIn = 4'h0;
        readCheck("iprMasked", 5'h10, 32'h1);
        axiWrite(5'h0C, 32'h1, 4'hF, 4'h0, 1'b1);
        checkValue("irqAck", {31'b0, irq}, 32'h0);
        readCheck("iprAck", 5'h10, 32'h0);

        // Edge mode on source 1 with a long high input.
        axiWrite(5'h04, 32'h2, 4'hF, 4'h0, 1'b1);
        axiWrite(5'h14, 32'h2, 4'hF, 4'h0, 1'b1);
        @(posedge tb_ACLK); #1;
        intrIn = 4'h2;
        repeat (100) @(posedge tb_ACLK);
        #1;
        readCheck("iprEdge", 5'h10, 32'h2);
        axiWrite(5'h0C, 32'h2, 4'hF, 4'h0, 1'b1);
        readCheck("iprEdgeAck", 5'h10, 32'h0);
        repeat (10) @(posedge tb_ACLK);
        #1;
        readCheck("iprEdgeStay", 5'h10, 32'h0);
        checkValue("irqEdgeStay", {31'b0, irq}, 32'h0);
        axiWrite(5'h14, 32'h0, 4'hF, 4'h0, 1'b1);
        readCheck("iprLevelRe", 5'h10, 32'h2);
        axiWrite(5'h14, 32'h2, 4'hF, 4'h0, 1'b1);
        axiWrite(5'h0C, 32'h2, 4'hF, 4'h0, 1'b1);
        readCheck("iprNoSpur", 5'h10, 32'h0);
        intrIn = 4'h0;

        // Event coinciding with an acknowledge keeps the bit pending.
        axiWrite(5'h04, 32'h1, 4'hF, 4'h0, 1'b1);
        axiWrite(5'h14, 32'h0, 4'hF, 4'h0, 1'b1);
        axiWrite(5'h0C, 32'h1, 4'hF, 4'h1, 1'b1);
        readCheck("iprSetWins", 5'h10, 32'h1);
        axiWrite(5'h0C, 32'h1, 4'hF, 4'h0, 1'b1);
        readCheck("iprCleared", 5'h10, 32'h0);

        // Software set with the global enable off, then on.
        axiWrite(5'h00, 32'h0, 4'hF, 4'h0, 1'b1);
        axiWrite(5'h18, 32'h8, 4'hF, 4'h0, 1'b1);
        readCheck("iprSw", 5'h10, 32'h8);
        checkValue("irqGieOff", {31'b0, irq}, 32'h0);
        axiWrite(5'h00, 32'h1, 4'hF, 4'h0, 1'b1);
        checkValue("irqGieOn", {31'b0, irq}, 32'h1);
        readCheck("iswrRd", 5'h18, 32'h0);
        readCheck("iarRd", 5'h0C, 32'h0);
        readCheck("unmapRd", 5'h1C, 32'h0);
        axiWrite(5'h04, 32'h0, 4'hF, 4'h0, 1'b1);
        readCheck("iprKeepIer", 5'h10, 32'h8);
        axiWrite(5'h0C, 32'h8, 4'hF, 4'h0, 1'b1);
        readCheck("iprSwClr", 5'h10, 32'h0);

        // Unmapped write with a stalled response, then reset mid-hold.
        axiWrite(5'h04, 32'h3, 4'hF, 4'h0, 1'b1);
        axiWrite(5'h14, 32'hF, 4'hF, 4'h0, 1'b1);
        axiWrite(5'h18, 32'h4, 4'hF, 4'h0, 1'b1);
        bready = 1'b0;
        axiWrite(5'h1C, 32'hFFFFFFFF, 4'hF, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_ACLK);
            checkValue("bvalidHold", {31'b0, bvalid}, 32'h1);
        end
        readCheck("ierUnmapped", 5'h04, 32'h3);
        readCheck("gieUnmapped", 5'h00, 32'h1);
        checkValue("irqPreRst", {31'b0, irq}, 32'h1);
        @(posedge tb_ACLK); #1;
        areset = 1'b1;
        repeat (2) @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        checkValue("rstBvalidMid", {31'b0, bvalid}, 32'h0);
        checkValue("rstIrqMid", {31'b0, irq}, 32'h0);
        @(posedge tb_ACLK); #1;
        areset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_ACLK);
            checkValue("bvalidPostRst", {31'b0, bvalid}, 32'h0);
            checkValue("rvalidPostRst", {31'b0, rvalid}, 32'h0);
        end
        bready = 1'b1;
        readCheck("gieAfterRst", 5'h00, 32'h0);
        readCheck("ierAfterRst", 5'h04, 32'h0);
        readCheck("iprAfterRst", 5'h10, 32'h0);
        readCheck("modeAfterRst", 5'h14, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
